// File: rtl/debug_probe_view.sv
// debug_probe_view
//   Registered debug-probe selector for the HEX/LCD display path. Picks one
//   of NUM_CH packed probe words per cycle, with live, freeze, timed
//   auto-scan and capture-on-step modes.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   probe_bus  NUM_CH*WIDTH packed probes, channel k at [k*WIDTH +: WIDTH]
//   sel        manual channel select
//   mode       00 live, 01 freeze, 10 auto-scan, 11 step-capture
//   step       level input (debounced key), rising edge detected here
//   disp_data  registered word to display
//   disp_ch    channel index of disp_data
//   disp_valid 1 when disp_ch < NUM_CH
//   changed    1-cycle pulse: disp_data changed while disp_ch held
module debug_probe_view #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 10,
    parameter int SEL_W  = 4,
    parameter int DWELL  = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] probe_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              mode,
    input  logic                    step,
    output logic [WIDTH-1:0]        disp_data,
    output logic [SEL_W-1:0]        disp_ch,
    output logic                    disp_valid,
    output logic                    changed
);

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'b00,
        MODE_FREEZE = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_STEP   = 2'b11
    } mode_t;

    // A 1-bit counter is kept even for DWELL=1 so the compare stays legal.
    localparam int                CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]    NUM_CH_W   = (SEL_W + 1)'(NUM_CH);

    function automatic logic in_range(input logic [SEL_W-1:0] ch);
        return ({1'b0, ch} < NUM_CH_W);
    endfunction

    // Fully decoded mux: any select without a matching channel yields zero.
    function automatic logic [WIDTH-1:0] probe_word(
        input logic [NUM_CH*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]        ch
    );
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == SEL_W'(k)) begin
                w = bus[k*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    mode_t             mode_q;
    logic              step_q;
    logic [SEL_W-1:0]  scan_ch;
    logic [CNT_W-1:0]  dwell_cnt;

    logic              step_rise;
    logic              scan_entry;
    logic [SEL_W-1:0]  entry_ch;
    logic [SEL_W-1:0]  scan_next_ch;
    logic              ld_en;
    logic [SEL_W-1:0]  ld_ch;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_valid;

    always_comb begin
        step_rise    = step & ~step_q;
        scan_entry   = (mode == MODE_SCAN) && (mode_q != MODE_SCAN);
        entry_ch     = in_range(sel) ? sel : '0;
        scan_next_ch = (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;

        ld_en = 1'b0;
        ld_ch = sel;
        case (mode)
            MODE_LIVE: begin
                ld_en = 1'b1;
            end
            MODE_SCAN: begin
                ld_en = 1'b1;
                ld_ch = scan_entry ? entry_ch : scan_ch;
            end
            MODE_STEP: begin
                ld_en = step_rise;
            end
            default: begin
                ld_en = 1'b0;
            end
        endcase

        ld_valid = in_range(ld_ch);
        ld_data  = probe_word(probe_bus, ld_ch);
    end

    // Output / state register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data  <= '0;
            disp_ch    <= '0;
            disp_valid <= 1'b0;
            changed    <= 1'b0;
            scan_ch    <= '0;
            dwell_cnt  <= '0;
            // Key held through reset must not look like a fresh press.
            step_q     <= 1'b1;
            // Anything but scan, so scan re-enters from sel after reset.
            mode_q     <= MODE_LIVE;
        end else begin
            step_q <= step;
            mode_q <= mode_t'(mode);

            if (ld_en) begin
                disp_ch    <= ld_ch;
                disp_data  <= ld_data;
                disp_valid <= ld_valid;
                changed    <= (ld_ch == disp_ch) && (ld_data != disp_data);
            end else begin
                changed    <= 1'b0;
            end

            if (scan_entry) begin
                scan_ch   <= entry_ch;
                dwell_cnt <= '0;
            end else if (mode == MODE_SCAN) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    scan_ch   <= scan_next_ch;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_probe_view.sv
module tb_debug_probe_view;

    localparam int W   = 32;
    localparam int N   = 10;
    localparam int SW  = 4;
    localparam int DW  = 4;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  probe_bus;
    logic [SW-1:0]   sel;
    logic [1:0]      mode;
    logic            step;
    logic [W-1:0]    disp_data;
    logic [SW-1:0]   disp_ch;
    logic            disp_valid;
    logic            changed;

    logic [W-1:0]    probe [N];

    // Small instance for the three-channel scan/wrap sequence
    logic [23:0]     probe3_bus;
    logic [1:0]      sel3;
    logic [1:0]      mode3;
    logic            step3;
    logic [7:0]      disp_data3;
    logic [1:0]      disp_ch3;
    logic            disp_valid3;
    logic            changed3;

    int n_vec;
    int n_bad;

    debug_probe_view #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW), .DWELL(DW)) dut (
        .clk(clk), .rst(rst), .probe_bus(probe_bus), .sel(sel), .mode(mode),
        .step(step), .disp_data(disp_data), .disp_ch(disp_ch),
        .disp_valid(disp_valid), .changed(changed)
    );

    debug_probe_view #(.WIDTH(8), .NUM_CH(3), .SEL_W(2), .DWELL(4)) dut3 (
        .clk(clk), .rst(rst), .probe_bus(probe3_bus), .sel(sel3), .mode(mode3),
        .step(step3), .disp_data(disp_data3), .disp_ch(disp_ch3),
        .disp_valid(disp_valid3), .changed(changed3)
    );

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_bus
            assign probe_bus[g*W +: W] = probe[g];
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_data;
    int           m_ch;
    bit           m_valid;
    bit           m_chg;
    int           m_scan;
    int           m_cnt;
    int           m_prev;
    bit           m_stepq;

    task automatic model_step();
        bit do_load;
        int ch;
        logic [W-1:0] nd;
        if (rst) begin
            m_data = '0; m_ch = 0; m_valid = 0; m_chg = 0;
            m_scan = 0; m_cnt = 0; m_stepq = 1; m_prev = 0;
        end else begin
            do_load = 0;
            ch = int'(sel);
            case (int'(mode))
                0: do_load = 1;
                2: begin
                    do_load = 1;
                    if (m_prev != 2) begin
                        ch = (int'(sel) < N) ? int'(sel) : 0;
                        m_scan = ch;
                        m_cnt = 0;
                    end else begin
                        ch = m_scan;
                        if (m_cnt == DW - 1) begin
                            m_cnt = 0;
                            m_scan = (m_scan + 1) % N;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
                3: do_load = step && !m_stepq;
                default: do_load = 0;
            endcase
            if (do_load) begin
                nd = (ch < N) ? probe[ch] : '0;
                m_chg = (ch == m_ch) && (nd != m_data);
                m_ch = ch;
                m_data = nd;
                m_valid = (ch < N);
            end else begin
                m_chg = 0;
            end
            m_stepq = step;
            m_prev = int'(mode);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit        rst;
        bit [1:0]  mode;
        bit [3:0]  sel;
        bit        step;
        int        pch;
        bit [31:0] pval;
        bit [31:0] e_data;
        bit [3:0]  e_ch;
        bit        e_valid;
        bit        e_chg;
    } vec_t;

    function automatic vec_t mk(bit r, bit [1:0] md, bit [3:0] s, bit st, int pc,
                                bit [31:0] pv, bit [31:0] ed, bit [3:0] ec, bit ev, bit ecg);
        vec_t v;
        v.rst = r; v.mode = md; v.sel = s; v.step = st; v.pch = pc; v.pval = pv;
        v.e_data = ed; v.e_ch = ec; v.e_valid = ev; v.e_chg = ecg;
        return v;
    endfunction

    function automatic logic [31:0] pinit(int k);
        return 32'h1000_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    vec_t tbl[$];
    int   exp3 [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0, 1};

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; mode = 2'b00; sel = '0; step = 1'b0;
        for (int k = 0; k < N; k++) probe[k] = pinit(k);
        probe3_bus = 24'hC2C1C0; sel3 = 2'd0; mode3 = 2'b00; step3 = 1'b0;

        // reset with nonzero probes
        repeat (3) tbl.push_back(mk(1, 0, 2, 0, -1, 0, 0, 0, 0, 0));
        // live
        tbl.push_back(mk(0, 0, 2,  0,  2, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1, 0));
        tbl.push_back(mk(0, 0, 12, 0, -1, 0, 0, 12, 0, 0));
        tbl.push_back(mk(0, 0, 1,  0,  1, 5, 5, 1, 1, 0));
        // freeze
        tbl.push_back(mk(0, 1, 1,  0, -1, 0, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3,  0,  1, 9, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3,  0, -1, 0, 5, 1, 1, 0));
        // back to live on the same channel: new data -> changed pulse
        tbl.push_back(mk(0, 0, 1,  0, -1, 0, 9, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1,  0, -1, 0, 9, 1, 1, 0));
        // step-capture
        tbl.push_back(mk(0, 3, 4,  0,  4, 7, 9, 1, 1, 0));
        tbl.push_back(mk(0, 3, 4,  1, -1, 0, 7, 4, 1, 0));
        tbl.push_back(mk(0, 3, 4,  1,  4, 8, 7, 4, 1, 0));
        tbl.push_back(mk(0, 3, 4,  0, -1, 0, 7, 4, 1, 0));
        tbl.push_back(mk(0, 3, 4,  1, -1, 0, 8, 4, 1, 1));
        tbl.push_back(mk(0, 3, 4,  1, -1, 0, 8, 4, 1, 0));
        tbl.push_back(mk(0, 3, 11, 0, -1, 0, 8, 4, 1, 0));
        tbl.push_back(mk(0, 3, 11, 1, -1, 0, 0, 11, 0, 0));
        // reset with key held, then key still held: no capture
        tbl.push_back(mk(1, 3, 4,  1, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 4,  1, -1, 0, 0, 0, 0, 0));
        // auto-scan from 8: entry edge, then 4 dwell edges per channel, wrap 9 -> 0
        repeat (5) tbl.push_back(mk(0, 2, 8, 0, -1, 0, pinit(8), 8, 1, 0));
        repeat (4) tbl.push_back(mk(0, 2, 8, 0, -1, 0, pinit(9), 9, 1, 0));
        tbl.push_back(mk(0, 2, 8, 0, -1, 0, pinit(0), 0, 1, 0));
        // reset mid-scan, restart from sel
        tbl.push_back(mk(1, 2, 8,  0, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 8,  0, -1, 0, pinit(8), 8, 1, 0));
        tbl.push_back(mk(0, 2, 13, 0, -1, 0, pinit(8), 8, 1, 0));
        // leave scan, re-enter with out-of-range sel -> starts at 0
        tbl.push_back(mk(0, 0, 13, 0, -1, 0, 0, 13, 0, 0));
        tbl.push_back(mk(0, 2, 13, 0, -1, 0, pinit(0), 0, 1, 0));
        // live probe change while scan holds the channel
        tbl.push_back(mk(0, 2, 13, 0,  0, 32'h1234, 32'h1234, 0, 1, 1));

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            mode = tbl[i].mode;
            sel  = tbl[i].sel;
            step = tbl[i].step;
            if (tbl[i].pch >= 0) probe[tbl[i].pch] = tbl[i].pval;
            tick();
            check($sformatf("tbl%0d.data", i),  disp_data,        tbl[i].e_data);
            check($sformatf("tbl%0d.ch", i),    32'(disp_ch),     32'(tbl[i].e_ch));
            check($sformatf("tbl%0d.valid", i), 32'(disp_valid),  32'(tbl[i].e_valid));
            check($sformatf("tbl%0d.chg", i),   32'(changed),     32'(tbl[i].e_chg));
        end

        // three-channel scan: entry edge shows sel, then 1,1,1,1,2,2,2,2,0,0,0,0,1
        mode = 2'b00;
        sel3 = 2'd1;
        mode3 = 2'b10;
        tick();
        check("scan3.entry_ch", 32'(disp_ch3), 32'd1);
        check("scan3.entry_data", 32'(disp_data3), 32'hC1);
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("scan3.ch%0d", i), 32'(disp_ch3), 32'(exp3[i]));
            check($sformatf("scan3.data%0d", i), 32'(disp_data3), 32'hC0 + 32'(exp3[i]));
        end
        mode3 = 2'b00;

        // randomized run against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 1) == 0)
                probe[$urandom_range(0, N - 1)] = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3));
            rst = ($urandom_range(0, 59) == 0);
            tick();
            check("rnd.data",  disp_data,        m_data);
            check("rnd.ch",    32'(disp_ch),     32'(m_ch));
            check("rnd.valid", 32'(disp_valid),  32'(m_valid));
            check("rnd.chg",   32'(changed),     32'(m_chg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
